// File: rtl/hex_word_to_ascii_stream.sv
// ---------------------------------------------------------------------------
// hex_word_to_ascii_stream
//
// Accepts a DATA_WIDTH-bit word over a valid/ready handshake and streams its
// hexadecimal representation as ASCII characters, one character per sink
// handshake. The runtime mode bits select upper/lower case hex letters,
// leading-zero blanking and an optional "0x" prefix. The mode bits are
// captured together with the word.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_data        word to convert
//   i_valid       i_data and the mode bits are valid
//   o_ready       block is idle and can accept a new word
//   i_lower       1 = a-f, 0 = A-F
//   i_blank       1 = suppress leading zero digits (at least one digit kept)
//   i_prefix      1 = emit "0x" before the digits
//   o_char        current ASCII character (zero-extended to CHAR_WIDTH)
//   o_char_valid  o_char is valid
//   i_char_ready  sink accepts o_char
//   o_last        o_char is the final character of the word
//   o_busy        a conversion is in progress
// ---------------------------------------------------------------------------
module hex_word_to_ascii_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CHAR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_lower,
    input  logic                  i_blank,
    input  logic                  i_prefix,
    output logic [CHAR_WIDTH-1:0] o_char,
    output logic                  o_char_valid,
    input  logic                  i_char_ready,
    output logic                  o_last,
    output logic                  o_busy
);

    localparam int NDIG  = DATA_WIDTH / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_X     = 8'h78;

    typedef enum logic [1:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGIT
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    lower_reg;
    logic [IDX_W-1:0]        start_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [CHAR_WIDTH-1:0]   char_reg;
    logic                    char_valid_reg;
    logic                    last_reg;

    // Nibble views of the incoming word and of the captured word.
    logic [3:0]      in_nib   [NDIG];
    logic [3:0]      data_nib [NDIG];
    logic [NDIG-1:0] in_nz;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nib
            assign in_nib[gi]   = i_data[gi*4 +: 4];
            assign data_nib[gi] = data_reg[gi*4 +: 4];
            assign in_nz[gi]    = |i_data[gi*4 +: 4];
        end
    endgenerate

    // Most-significant non-zero nibble of the incoming word; 0 for a zero
    // word so that blanking still leaves a single "0" digit.
    logic [IDX_W-1:0] msnz_idx;
    always_comb begin
        msnz_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (in_nz[i]) begin
                msnz_idx = IDX_W'(i);
            end
        end
    end

    logic [IDX_W-1:0] accept_start;
    assign accept_start = i_blank ? msnz_idx : IDX_W'(NDIG - 1);

    function automatic logic [7:0] to_ascii(input logic [3:0] nib, input logic lower);
        logic [7:0] base;
        if (nib < 4'd10) begin
            base = ASCII_ZERO;
        end else begin
            // 'A'-10 = 0x37, 'a'-10 = 0x57
            base = lower ? 8'h57 : 8'h37;
        end
        return base + {4'h0, nib};
    endfunction

    logic [IDX_W-1:0] idx_dec;
    logic [7:0]       accept_char;
    logic [7:0]       start_char;
    logic [7:0]       next_char;
    logic             advance;

    assign idx_dec     = idx_reg - 1'b1;
    assign accept_char = to_ascii(in_nib[accept_start], i_lower);
    assign start_char  = to_ascii(data_nib[start_reg], lower_reg);
    assign next_char   = to_ascii(data_nib[idx_dec], lower_reg);
    assign advance     = char_valid_reg && i_char_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            data_reg       <= '0;
            lower_reg      <= 1'b0;
            start_reg      <= '0;
            idx_reg        <= '0;
            char_reg       <= CHAR_WIDTH'(ASCII_SPACE);
            char_valid_reg <= 1'b0;
            last_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        data_reg       <= i_data;
                        lower_reg      <= i_lower;
                        start_reg      <= accept_start;
                        idx_reg        <= accept_start;
                        char_valid_reg <= 1'b1;
                        if (i_prefix) begin
                            state_reg <= PFX0;
                            char_reg  <= CHAR_WIDTH'(ASCII_ZERO);
                            last_reg  <= 1'b0;
                        end else begin
                            // No prefix: the first digit goes out directly.
                            state_reg <= DIGIT;
                            char_reg  <= CHAR_WIDTH'(accept_char);
                            last_reg  <= (accept_start == '0);
                        end
                    end
                end

                PFX0: begin
                    if (advance) begin
                        state_reg <= PFX1;
                        char_reg  <= CHAR_WIDTH'(ASCII_X);
                        last_reg  <= 1'b0;
                    end
                end

                PFX1: begin
                    if (advance) begin
                        state_reg <= DIGIT;
                        idx_reg   <= start_reg;
                        char_reg  <= CHAR_WIDTH'(start_char);
                        last_reg  <= (start_reg == '0);
                    end
                end

                DIGIT: begin
                    if (advance) begin
                        if (idx_reg == '0) begin
                            // o_char keeps its value; only valid drops.
                            state_reg      <= IDLE;
                            char_valid_reg <= 1'b0;
                            last_reg       <= 1'b0;
                        end else begin
                            idx_reg  <= idx_dec;
                            char_reg <= CHAR_WIDTH'(next_char);
                            last_reg <= (idx_dec == '0);
                        end
                    end
                end

                default: begin
                    state_reg      <= IDLE;
                    char_valid_reg <= 1'b0;
                    last_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = (state_reg == IDLE);
    assign o_busy       = (state_reg != IDLE);
    assign o_char       = char_reg;
    assign o_char_valid = char_valid_reg;
    assign o_last       = last_reg;

endmodule

// File: tb/tb_hex_word_to_ascii_stream.sv
// ---------------------------------------------------------------------------
// Testbench for hex_word_to_ascii_stream with DATA_WIDTH=16. A table of
// words with hand-computed character sequences is streamed with the sink
// always ready; hand-written sequences cover held i_valid, backpressure and
// reset in the middle of a stream.
// ---------------------------------------------------------------------------
module tb_hex_word_to_ascii_stream;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          i_lower;
    logic          i_blank;
    logic          i_prefix;
    logic [CW-1:0] o_char;
    logic          o_char_valid;
    logic          i_char_ready;
    logic          o_last;
    logic          o_busy;

    int total = 0;
    int bad   = 0;

    hex_word_to_ascii_stream #(
        .DATA_WIDTH(DW),
        .CHAR_WIDTH(CW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_lower     (i_lower),
        .i_blank     (i_blank),
        .i_prefix    (i_prefix),
        .o_char      (o_char),
        .o_char_valid(o_char_valid),
        .i_char_ready(i_char_ready),
        .o_last      (o_last),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] data;
        logic        lower;
        logic        blank;
        logic        prefix;
        int          n;
        logic [47:0] exp;   // first character in the top byte
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Called at the negedge where a word has just been handed over; drops
    // i_valid for the following accept.
    task automatic send(input logic [15:0] d, input logic lo, input logic bl, input logic pf);
        check("ready_before_accept", {31'b0, o_ready}, 32'd1);
        i_data   = d;
        i_lower  = lo;
        i_blank  = bl;
        i_prefix = pf;
        i_valid  = 1'b1;
        @(negedge i_clk);
        i_valid  = 1'b0;
    endtask

    // Called at the negedge where the first character should be valid.
    // With bp=1 the sink ready follows the pattern 1,0,0,1,...
    task automatic stream_check(input string name, input logic [47:0] exp, input int n, input bit bp);
        int k;
        int cyc;
        logic rdy;
        logic [3:0] pat;
        pat = 4'b1001;   // bit 3 = cycle 0
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 60) begin
            check({name, "_valid"}, {31'b0, o_char_valid}, 32'd1);
            check({name, "_char"},  {24'b0, o_char}, {24'b0, exp[47 - 8*k -: 8]});
            check({name, "_last"},  {31'b0, o_last}, (k == n - 1) ? 32'd1 : 32'd0);
            check({name, "_busy"},  {31'b0, o_busy}, 32'd1);
            check({name, "_ready_low"}, {31'b0, o_ready}, 32'd0);
            rdy = bp ? pat[3 - (cyc % 4)] : 1'b1;
            i_char_ready = rdy;
            if (rdy) k++;
            cyc++;
            @(negedge i_clk);
        end
        if (cyc >= 60) begin
            bad++;
            total++;
            $display("FAIL %s_timeout: got %0d chars required %0d", name, k, n);
        end
        check({name, "_done_valid"}, {31'b0, o_char_valid}, 32'd0);
        check({name, "_done_ready"}, {31'b0, o_ready}, 32'd1);
        check({name, "_done_busy"},  {31'b0, o_busy}, 32'd0);
        i_char_ready = 1'b1;
        $display("word %s: %0d chars in %0d cycles, bad so far %0d", name, k, cyc, bad);
    endtask

    initial begin
        vecs[0] = '{16'h00A5, 1'b0, 1'b1, 1'b1, 4, 48'h3078_4135_0000};
        vecs[1] = '{16'h00A5, 1'b0, 1'b0, 1'b0, 4, 48'h3030_4135_0000};
        vecs[2] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1, 48'h3000_0000_0000};
        vecs[3] = '{16'hBEEF, 1'b1, 1'b0, 1'b0, 4, 48'h6265_6566_0000};
        vecs[4] = '{16'h0000, 1'b0, 1'b0, 1'b1, 6, 48'h3078_3030_3030};
        vecs[5] = '{16'hF00C, 1'b0, 1'b1, 1'b0, 4, 48'h4630_3043_0000};
        vecs[6] = '{16'h0009, 1'b1, 1'b1, 1'b1, 3, 48'h3078_3900_0000};
        vecs[7] = '{16'h0C3D, 1'b1, 1'b1, 1'b0, 3, 48'h6333_6400_0000};

        i_rst_n      = 1'b0;
        i_data       = '0;
        i_valid      = 1'b0;
        i_lower      = 1'b0;
        i_blank      = 1'b0;
        i_prefix     = 1'b0;
        i_char_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_char",  {24'b0, o_char}, 32'h20);
        check("rst_valid", {31'b0, o_char_valid}, 32'd0);
        check("rst_last",  {31'b0, o_last}, 32'd0);
        check("rst_busy",  {31'b0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", {31'b0, o_ready}, 32'd1);

        // Table-driven words, sink always ready
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].data, vecs[v].lower, vecs[v].blank, vecs[v].prefix);
            stream_check($sformatf("vec%0d", v), vecs[v].exp, vecs[v].n, 1'b0);
        end

        // i_valid held high with a new word during a stream: the new word
        // waits for o_ready and the running stream is unaffected.
        check("hold_ready_before", {31'b0, o_ready}, 32'd1);
        i_data  = 16'hBEEF;
        i_lower = 1'b1;
        i_blank = 1'b0;
        i_prefix = 1'b0;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_data  = 16'h1234;
        i_lower = 1'b0;
        i_prefix = 1'b1;
        i_blank = 1'b1;
        stream_check("held_beef", 48'h6265_6566_0000, 4, 1'b0);
        // o_ready is high now with i_valid still asserted -> accepted here.
        i_prefix = 1'b0;
        i_blank  = 1'b0;
        @(negedge i_clk);
        i_valid = 1'b0;
        stream_check("bp_1234", 48'h3132_3334_0000, 4, 1'b1);

        // Reset during the second character
        send(16'h00A5, 1'b0, 1'b1, 1'b1);
        i_char_ready = 1'b1;
        check("mid_c0", {24'b0, o_char}, 32'h30);
        @(negedge i_clk);
        check("mid_c1", {24'b0, o_char}, 32'h78);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("mid_rst_valid", {31'b0, o_char_valid}, 32'd0);
        check("mid_rst_char",  {24'b0, o_char}, 32'h20);
        check("mid_rst_busy",  {31'b0, o_busy}, 32'd0);
        check("mid_rst_last",  {31'b0, o_last}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("mid_rst_ready", {31'b0, o_ready}, 32'd1);
        send(16'h1234, 1'b0, 1'b0, 1'b0);
        stream_check("after_rst", 48'h3132_3334_0000, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_word_to_ascii_stream.md
Name: hex_word_to_ascii_stream

Overview:
Sequential successor to the 4-bit combinational hex-to-ASCII converter. It accepts a parametrised-width word over a valid/ready handshake and streams its hexadecimal representation as ASCII characters, one per handshake, to a character sink such as the LCD write controller or the UART TX. Three runtime modes are supported: upper/lower case, leading-zero blanking and an optional "0x" prefix. It sits between the Viterbi decoder debug/status taps and the display/console path.

Parameters:
DATA_WIDTH, 32, input word width in bits; must be a multiple of 4 and at least 4; NDIG = DATA_WIDTH/4 digits.
CHAR_WIDTH, 8, ASCII character width; values above 8 zero-extend the character.

Ports:
i_clk  input  1  clock; all logic is rising-edge.
i_rst_n  input  1  synchronous, active-low reset.
i_data  input  DATA_WIDTH  word to convert.
i_valid  input  1  i_data and the mode bits are valid.
o_ready  output  1  block can accept a new word.
i_lower  input  1  1 = digits a-f as 0x61-0x66; 0 = A-F as 0x41-0x46.
i_blank  input  1  1 = suppress leading zero digits.
i_prefix  input  1  1 = emit "0x" (0x30, 0x78) before the digits.
o_char  output  CHAR_WIDTH  current ASCII character.
o_char_valid  output  1  o_char is valid.
i_char_ready  input  1  sink accepts o_char.
o_last  output  1  o_char is the final character of the word; qualified by o_char_valid.
o_busy  output  1  a conversion is in progress (state is not IDLE).

Behaviour:
- Reset (i_rst_n low at a clock edge): state goes to IDLE; o_char=0x20; o_char_valid=0; o_last=0; o_busy=0. o_ready is 1 from the first cycle after reset is released. Reset during an active stream aborts it immediately. No partial character is held over.
- States: IDLE, PFX0, PFX1, DIGIT.
- Accept: i_valid && o_ready at edge T. This latches i_data, i_lower, i_blank and i_prefix. It also latches the start index:
  - with i_blank=0, start index = NDIG-1;
  - with i_blank=1, start index = the most-significant non-zero nibble, or 0 if the word is 0, so at least one digit is always emitted.
- After accept, the next state is PFX0 if the prefix bit is latched, otherwise DIGIT. The first character is valid at T+1 (registered output; 1-cycle latency).
- o_ready = (state==IDLE). The block never accepts a word while streaming.
- Character advance occurs only on o_char_valid && i_char_ready:
  - PFX0 (o_char 0x30) -> PFX1;
  - PFX1 (o_char 0x78) -> DIGIT at the start index;
  - DIGIT at index k outputs the ASCII of nibble k, then decrements k;
  - after index 0 is accepted, the state goes to IDLE.
- Digit mapping: 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46, or 0x61-0x66 when the latched lower bit is 1.
- Backpressure: while o_char_valid=1 and i_char_ready=0, o_char, o_last and state hold stable. i_char_ready is ignored while o_char_valid=0.
- o_last=1 only in DIGIT with index 0.
- Return path: the cycle after the last handshake, state=IDLE, o_char_valid=0 and o_ready=1. Minimum word period is chars+1 cycles.
- Input changes on i_data or the mode bits after accept have no effect on the current stream.
- o_char holds its last value in IDLE; only o_char_valid qualifies it.

Test Plan:
- DATA_WIDTH=16; i_data=0x00A5, prefix=1, blank=1, lower=0, i_char_ready=1 -> o_char sequence 0x30, 0x78, 0x41, 0x35 on 4 consecutive cycles starting T+1; o_last only on 0x35; o_ready=1 at T+5.
- Same word with blank=0, prefix=0 -> 0x30, 0x30, 0x41, 0x35.
- i_data=0x0000, blank=1, prefix=0 -> single 0x30 with o_last=1.
- i_data=0xBEEF, lower=1 -> 0x62, 0x65, 0x65, 0x66. Then drive i_data=0x1234 with i_valid held high during the stream -> it is not accepted until o_ready returns.
- Backpressure: i_char_ready toggling 1,0,0,1,… on 0x1234 -> o_char stable through stalls; exactly 4 characters delivered (0x31, 0x32, 0x33, 0x34), none duplicated or dropped.
- Drive i_rst_n=0 for one edge during the second character -> next cycle o_char_valid=0, o_char=0x20, o_busy=0. A new word accepted afterwards streams correctly from its first character.
